uart_tx_arbiter: RTL

Round-robin arbiter that shares the single UART transmit byte path among `NUM_REQ` requesters, such as the CPU register port, a DMA channel and a debug/console source. Each requester sends a packet of bytes. The grant is locked to one requester until it signals the last byte, or until it stalls longer than `TIMEOUT_CYCLE`. Winning bytes pass through a one-entry output register that feeds the UART TX holding/FIFO input.

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX byte path through a one-entry output register.
// Define UART_ARB_TIMEOUT_EN to compile in forced release of a grant stalled for TIMEOUT_CYCLE cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT_CYCLE = 6
) (
    input  logic                          apb_clk_in,
    input  logic                          apb_rstn_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]            req_last_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [NUM_REQ-1:0]            grant_out,
    output logic                          tx_valid_out,
    output logic [DATA_WIDTH-1:0]         tx_data_out,
    input  logic                          tx_ready_in,
    output logic                          busy_out,
    output logic                          timeout_pulse_out
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nx;
    logic [IW-1:0] owner, ptr, pick, idx, owner_inc;
    logic can_load, xfer, rel_last, rel_to, rel;

    assign can_load  = !tx_valid_out || tx_ready_in;
    assign xfer      = (state == LOCKED) && req_valid_in[owner] && can_load;
    assign rel_last  = xfer && req_last_in[owner];
    assign rel       = rel_last || rel_to;
    assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    assign busy_out  = (state == LOCKED) || tx_valid_out;

    // Scan downward so the lowest rotated offset from ptr wins.
    always_comb begin
        pick = ptr;
        idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid_in[idx]) pick = idx;
        end
    end

    always_comb begin
        grant_out            = '0;
        req_ready_out        = '0;
        grant_out[owner]     = state == LOCKED;
        req_ready_out[owner] = (state == LOCKED) && can_load;
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (|req_valid_in ? LOCKED : IDLE) : (rel ? IDLE : LOCKED);
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) state <= IDLE;
        else              state <= state_nx;
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            owner        <= '0;
            ptr          <= '0;
            tx_valid_out <= 1'b0;
            tx_data_out  <= '0;
        end else begin
            if (state == IDLE && |req_valid_in) owner <= pick;
            if (rel) ptr <= owner_inc;
            if (xfer) begin
                tx_valid_out <= 1'b1;
                tx_data_out  <= DATA_WIDTH'(req_data_in >> (owner * DATA_WIDTH));
            end else if (tx_ready_in) begin
                tx_valid_out <= 1'b0;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLE + 1);
    logic [CW-1:0] stall;

    // Fires on the TIMEOUT_CYCLE-th consecutive idle cycle of the owner.
    assign rel_to = (state == LOCKED) && !req_valid_in[owner] && (stall == CW'(TIMEOUT_CYCLE - 1));

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            stall             <= '0;
            timeout_pulse_out <= 1'b0;
        end else begin
            stall             <= (state == LOCKED && !req_valid_in[owner] && !rel_to) ? stall + CW'(1) : '0;
            timeout_pulse_out <= rel_to && !rel_last;
        end
    end
`else
    logic unused_timeout;
    assign rel_to            = 1'b0;
    assign timeout_pulse_out = 1'b0;
    assign unused_timeout    = |TIMEOUT_CYCLE;
`endif
endmodule
